// File: rtl/branch_resolve_unit_if.sv
// E->M branch resolution bus: E-stage branch operands in, M-stage outcome,
// predictor update, history repair and performance counters out.
interface branch_resolve_unit_if #(
  parameter int GHR_W = 10,
  parameter int CNT_W = 32
);
  logic              stallM;
  logic              flushM;
  logic              branchE;
  logic [31:0]       instrE;
  logic [31:0]       pcE;
  logic [31:0]       rs_valE;
  logic [31:0]       rt_valE;
  logic              pred_takeE;
  logic              branchM;
  logic              actual_takeM;
  logic              pred_takeM;
  logic              mispredictM;
  logic              flush_req;
  logic [31:0]       redirect_pc;
  logic              upd_valid;
  logic [GHR_W-1:0]  upd_index;
  logic              upd_taken;
  logic [GHR_W-1:0]  ghr_arch;
  logic [GHR_W-1:0]  ghr_recover;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  // Pipeline side driving E-stage operands
  modport master (
    output stallM, flushM, branchE, instrE, pcE, rs_valE, rt_valE, pred_takeE,
    input  branchM, actual_takeM, pred_takeM, mispredictM, flush_req, redirect_pc,
           upd_valid, upd_index, upd_taken, ghr_arch, ghr_recover, branch_cnt, mispred_cnt
  );

  // Branch resolve unit
  modport slave (
    input  stallM, flushM, branchE, instrE, pcE, rs_valE, rt_valE, pred_takeE,
    output branchM, actual_takeM, pred_takeM, mispredictM, flush_req, redirect_pc,
           upd_valid, upd_index, upd_taken, ghr_arch, ghr_recover, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates conditional branches in E, registers the
// outcome into M, and from M drives the front-end flush/redirect, the
// predictor update beat, committed global history and perf counters.
module branch_resolve_unit #(
  parameter int GHR_W = 10,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);
  logic [5:0]        op;
  logic [4:0]        rtf;
  logic              recogE;
  logic              condE;
  logic              isBrE;
  logic [31:0]       targetE;
  logic [31:0]       fallE;

  logic              brM;
  logic              actM;
  logic              predM;
  logic [31:0]       redirM;
  logic [GHR_W-1:0]  pcIdxM;
  logic [GHR_W-1:0]  ghr;
  logic [CNT_W-1:0]  bCnt;
  logic [CNT_W-1:0]  mCnt;

  logic              mispred;
  logic              fire;
  logic              flushFire;

  // Decode the branch encoding and evaluate its condition on forwarded operands
  always_comb begin
    op     = bus.instrE[31:26];
    rtf    = bus.instrE[20:16];
    recogE = 1'b0;
    condE  = 1'b0;
    case (op)
      6'b000100: begin recogE = 1'b1; condE = (bus.rs_valE == bus.rt_valE); end
      6'b000101: begin recogE = 1'b1; condE = (bus.rs_valE != bus.rt_valE); end
      6'b000110: begin recogE = 1'b1; condE = ($signed(bus.rs_valE) <= 32'sd0); end
      6'b000111: begin recogE = 1'b1; condE = ($signed(bus.rs_valE) > 32'sd0); end
      6'b000001: begin
        case (rtf)
          5'b00000, 5'b10000: begin recogE = 1'b1; condE = bus.rs_valE[31]; end
          5'b00001, 5'b10001: begin recogE = 1'b1; condE = ~bus.rs_valE[31]; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign isBrE   = bus.branchE & recogE;
  assign targetE = bus.pcE + 32'd4 + {{14{bus.instrE[15]}}, bus.instrE[15:0], 2'b00};
  assign fallE   = bus.pcE + 32'd8;

  // M-stage outcome is one-shot: it fires only in a cycle where M is not held
  assign mispred   = brM & (actM ^ predM);
  assign fire      = brM & ~bus.stallM;
  assign flushFire = mispred & ~bus.stallM;

  // E->M register plus committed history and saturating counters.
  // A stall holds the whole M slot even under flushM: the flush only kills
  // the branch trying to enter, the held branch still fires on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      brM    <= 1'b0;
      actM   <= 1'b0;
      predM  <= 1'b0;
      redirM <= '0;
      pcIdxM <= '0;
      ghr    <= '0;
      bCnt   <= '0;
      mCnt   <= '0;
    end else begin
      if (!bus.stallM) begin
        if (bus.flushM) begin
          brM <= 1'b0;
        end else begin
          brM    <= isBrE;
          actM   <= condE;
          predM  <= bus.pred_takeE;
          redirM <= condE ? targetE : fallE;
          pcIdxM <= bus.pcE[GHR_W+1:2];
        end
      end
      if (fire) ghr <= {ghr[GHR_W-2:0], actM};
      if (fire && !(&bCnt)) bCnt <= bCnt + 1'b1;
      if (flushFire && !(&mCnt)) mCnt <= mCnt + 1'b1;
    end
  end

  assign bus.branchM      = brM;
  assign bus.actual_takeM = actM;
  assign bus.pred_takeM   = predM;
  assign bus.mispredictM  = mispred;
  assign bus.flush_req    = flushFire;
  assign bus.redirect_pc  = redirM;
  assign bus.upd_valid    = fire;
  assign bus.upd_index    = pcIdxM ^ ghr;
  assign bus.upd_taken    = actM;
  assign bus.ghr_arch     = ghr;
  assign bus.ghr_recover  = {ghr[GHR_W-2:0], actM};
  assign bus.branch_cnt   = bCnt;
  assign bus.mispred_cnt  = mCnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_branch_resolve_unit;
  localparam int GHR_W = 10;
  localparam int CNT_W = 4;
  localparam int GMASK = (1 << GHR_W) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.GHR_W(GHR_W), .CNT_W(CNT_W)) bus();

  branch_resolve_unit #(.GHR_W(GHR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int nPass = 0;
  int nTot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else nPass++;
  endtask

  // ---------------- behavioural model ----------------
  bit          armed = 0;
  bit          mV;
  bit          mAct, mPred;
  logic [31:0] mRedir, mPc;
  int          mGhr, mB, mM;

  function automatic void evalBranch(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt, output bit ok, output bit tk);
    int op;
    int rf;
    op = int'(ins[31:26]);
    rf = int'(ins[20:16]);
    ok = 1; tk = 0;
    if (op == 4)      tk = (rs == rt);
    else if (op == 5) tk = !(rs == rt);
    else if (op == 6) tk = ($signed(rs) < 1);
    else if (op == 7) tk = !($signed(rs) < 1);
    else if (op == 1 && (rf == 0 || rf == 16)) tk = ($signed(rs) < 0);
    else if (op == 1 && (rf == 1 || rf == 17)) tk = !($signed(rs) < 0);
    else ok = 0;
  endfunction

  function automatic bit expUpd();   return mV && !bus.stallM; endfunction
  function automatic bit expFlush(); return mV && (mAct != mPred) && !bus.stallM; endfunction

  // Advance the model at each active edge from the inputs presented
  always @(posedge clk) begin
    bit ok, tk;
    int off;
    armed = 1;
    if (rst) begin
      mV = 0; mAct = 0; mPred = 0; mRedir = 0; mPc = 0; mGhr = 0; mB = 0; mM = 0;
    end else begin
      if (expFlush() && mM < CMAX) mM = mM + 1;
      if (expUpd()) begin
        mGhr = ((mGhr * 2) + int'(mAct)) & GMASK;
        if (mB < CMAX) mB = mB + 1;
      end
      if (!bus.stallM) begin
        if (bus.flushM) mV = 0;
        else begin
          evalBranch(bus.instrE, bus.rs_valE, bus.rt_valE, ok, tk);
          off    = int'($signed(bus.instrE[15:0]));
          mV     = bus.branchE && ok;
          mAct   = tk;
          mPred  = bus.pred_takeE;
          mPc    = bus.pcE;
          mRedir = tk ? (bus.pcE + 32'd4 + 32'(off * 4)) : (bus.pcE + 32'd8);
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("branchM",     32'(bus.branchM),     32'(mV));
      chk("flush_req",   32'(bus.flush_req),   32'(expFlush()));
      chk("upd_valid",   32'(bus.upd_valid),   32'(expUpd()));
      chk("mispredictM", 32'(bus.mispredictM), 32'(mV && (mAct != mPred)));
      chk("ghr_arch",    32'(bus.ghr_arch),    32'(mGhr));
      chk("branch_cnt",  32'(bus.branch_cnt),  32'(mB));
      chk("mispred_cnt", 32'(bus.mispred_cnt), 32'(mM));
      if (mV) begin
        chk("actual_takeM", 32'(bus.actual_takeM), 32'(mAct));
        chk("pred_takeM",   32'(bus.pred_takeM),   32'(mPred));
        chk("redirect_pc",  bus.redirect_pc,       mRedir);
        chk("ghr_recover",  32'(bus.ghr_recover),  32'(((mGhr * 2) + int'(mAct)) & GMASK));
      end
      if (expUpd()) begin
        chk("upd_taken", 32'(bus.upd_taken), 32'(mAct));
        chk("upd_index", 32'(bus.upd_index), 32'((int'(mPc >> 2) ^ mGhr) & GMASK));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.branchE = 0; bus.stallM = 0; bus.flushM = 0;
  endtask

  task automatic setBr(input logic [5:0] op, input logic [4:0] rf, input logic [15:0] imm,
                       input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                       input logic pred);
    bus.branchE = 1; bus.instrE = {op, 5'd3, rf, imm};
    bus.pcE = pc; bus.rs_valE = rs; bus.rt_valE = rt; bus.pred_takeE = pred;
  endtask

  // advance one clock and land on the following negedge for sampling
  task automatic cyc();
    @(posedge clk); #1; @(negedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1; idle(); cyc(); rst = 0;
  endtask

  logic [31:0] cntSnap;
  logic [31:0] bSnap;

  initial begin
    idle(); bus.instrE = 0; bus.pcE = 0; bus.rs_valE = 0; bus.rt_valE = 0; bus.pred_takeE = 0;
    rst = 1; cyc(); cyc();
    chk("rst_branchM", 32'(bus.branchM), 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    chk("rst_flush", 32'(bus.flush_req), 0);
    chk("rst_cnt", 32'(bus.mispred_cnt), 0);
    rst = 0;

    // beq taken, predicted not-taken
    setBr(6'b000100, 5'd2, 16'h0004, 32'h100, 32'd5, 32'd5, 1'b0); cyc(); idle();
    chk("beq_branchM", 32'(bus.branchM), 1);
    chk("beq_act", 32'(bus.actual_takeM), 1);
    chk("beq_flush", 32'(bus.flush_req), 1);
    chk("beq_redirect", bus.redirect_pc, 32'h114);
    cyc();
    chk("beq_mcnt", 32'(bus.mispred_cnt), 1);
    chk("beq_ghr", 32'(bus.ghr_arch), 1);

    // bne not taken, correctly predicted
    doReset();
    setBr(6'b000101, 5'd2, 16'h0010, 32'h200, 32'd7, 32'd7, 1'b0); cyc(); idle();
    chk("bne_mis", 32'(bus.mispredictM), 0);
    chk("bne_flush", 32'(bus.flush_req), 0);
    chk("bne_upd", 32'(bus.upd_valid), 1);
    chk("bne_taken", 32'(bus.upd_taken), 0);
    chk("bne_index", 32'(bus.upd_index), 32'h080);
    cyc();
    chk("bne_bcnt", 32'(bus.branch_cnt), 1);

    // bltzal with target wrapping to 0; then an unrecognised rt field
    setBr(6'b000001, 5'b10000, 16'hFFFF, 32'h0, 32'h80000000, 32'h0, 1'b0); cyc(); idle();
    chk("bltzal_act", 32'(bus.actual_takeM), 1);
    chk("bltzal_redirect", bus.redirect_pc, 32'h0);
    setBr(6'b000001, 5'b00010, 16'hFFFF, 32'h0, 32'h80000000, 32'h0, 1'b0); cyc(); idle();
    chk("badrt_branchM", 32'(bus.branchM), 0);
    chk("badrt_upd", 32'(bus.upd_valid), 0);

    // mispredict held in M by a 3-cycle stall fires exactly once on release
    cntSnap = 32'(bus.mispred_cnt); bSnap = 32'(bus.branch_cnt);
    setBr(6'b000111, 5'd0, 16'h0008, 32'h400, 32'd1, 32'd0, 1'b0);
    @(posedge clk); #1; idle(); bus.stallM = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall_flush", 32'(bus.flush_req), 0);
      chk("stall_upd", 32'(bus.upd_valid), 0);
      @(posedge clk); #1;
    end
    bus.stallM = 0; @(negedge clk); #1;
    chk("rel_flush", 32'(bus.flush_req), 1);
    chk("rel_upd", 32'(bus.upd_valid), 1);
    cyc();
    chk("rel_flush_once", 32'(bus.flush_req), 0);
    chk("rel_mcnt", 32'(bus.mispred_cnt), cntSnap + 1);
    chk("rel_bcnt", 32'(bus.branch_cnt), bSnap + 1);

    // flushM kills a mispredicting branch in E
    cntSnap = 32'(bus.mispred_cnt);
    setBr(6'b000100, 5'd2, 16'h0004, 32'h500, 32'd1, 32'd1, 1'b0); bus.flushM = 1; cyc(); idle();
    chk("flm_branchM", 32'(bus.branchM), 0);
    chk("flm_flush", 32'(bus.flush_req), 0);
    cyc();
    chk("flm_mcnt", 32'(bus.mispred_cnt), cntSnap);

    // reset with a branch sitting in M
    setBr(6'b000100, 5'd2, 16'h0004, 32'h600, 32'd1, 32'd1, 1'b0); cyc(); idle();
    chk("prerst_branchM", 32'(bus.branchM), 1);
    rst = 1; cyc(); 
    chk("rstM_branchM", 32'(bus.branchM), 0);
    chk("rstM_flush", 32'(bus.flush_req), 0);
    chk("rstM_redirect", bus.redirect_pc, 0);
    chk("rstM_ghr", 32'(bus.ghr_arch), 0);
    rst = 0;

    // 16 back-to-back mispredicts saturate the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      setBr(6'b000100, 5'd2, 16'h0004, 32'(i * 4), 32'd2, 32'd2, 1'b0);
      @(posedge clk); #1;
    end
    idle(); cyc(); cyc();
    chk("sat_mcnt", 32'(bus.mispred_cnt), 32'hF);
    chk("sat_ghr", 32'(bus.ghr_arch), 32'h3FF);

    // randomized traffic
    doReset();
    for (int n = 0; n < 4000; n++) begin
      logic [5:0]  op;
      logic [4:0]  rf;
      logic [31:0] rs, rt;
      case ($urandom_range(0, 7))
        0: op = 6'b000100; 1: op = 6'b000101; 2: op = 6'b000110; 3: op = 6'b000111;
        4, 5: op = 6'b000001; 6: op = 6'b100011; default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rf = 5'b00000; 1: rf = 5'b00001; 2: rf = 5'b10000; 3: rf = 5'b10001;
        default: rf = 5'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rs = 32'h0; 1: rs = 32'h1; 2: rs = 32'hFFFFFFFF; 3: rs = 32'h80000000;
        default: rs = $urandom;
      endcase
      rt = $urandom_range(0, 1) ? rs : $urandom;
      setBr(op, rf, 16'($urandom), $urandom, rs, rt, 1'($urandom));
      bus.branchE = ($urandom_range(0, 9) < 7);
      bus.stallM  = ($urandom_range(0, 9) < 2);
      bus.flushM  = ($urandom_range(0, 9) < 1);
      rst         = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 0; idle(); cyc();

    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end
endmodule
